// File: rtl/seq_shifter.sv
// ---------------------------------------------------------------------------
// seq_shifter
//   Bit-serial shifter: one bit position per clock. It gives the same results
//   as the combinational barrel shifter, but uses a single 1-bit shift stage
//   instead of a log-depth mux tree.
//
//   Fill rules:
//     right logical    : MSB <- 0
//     right arithmetic : MSB <- current MSB (sign replicate)
//     left  logical    : LSB <- 0
//     left  arithmetic : LSB <- current bit 0 (LSB replicate)
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   request carries a valid operand
//   in_ready   block is idle and can accept a request
//   i_data     operand
//   shamt      shift amount (0 .. 2^SHAMT_WIDTH-1)
//   L_R        1 = shift right, 0 = shift left
//   A_L        1 = arithmetic fill, 0 = logical (zero) fill
//   out_valid  data_out holds a completed result
//   out_ready  consumer accepts the result
//   data_out   shifted result, held until the next completion
//   busy       an operation is in flight or waiting to be consumed
// ---------------------------------------------------------------------------
module seq_shifter #(
    parameter int DATA_WIDTH  = 8,
    parameter int SHAMT_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  i_data,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic                   L_R,
    input  logic                   A_L,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [SHAMT_WIDTH-1:0]  cnt;
    logic [DATA_WIDTH-1:0]   work;
    logic [DATA_WIDTH-1:0]   work_shifted;
    logic                    mode_right;
    logic                    mode_arith;
    logic                    accept;
    logic                    last_step;

    // One-position shift with the barrel shifter's fill rules.
    function automatic logic [DATA_WIDTH-1:0] shift_one(
        input logic [DATA_WIDTH-1:0] v,
        input logic                  right,
        input logic                  arith
    );
        logic fill;
        if (right) begin
            fill = arith ? v[DATA_WIDTH-1] : 1'b0;
            return {fill, v[DATA_WIDTH-1:1]};
        end else begin
            fill = arith ? v[0] : 1'b0;
            return {v[DATA_WIDTH-2:0], fill};
        end
    endfunction

    assign accept       = in_valid && (state == IDLE);
    assign last_step    = (state == SHIFT) && (cnt == SHAMT_WIDTH'(1));
    assign work_shifted = shift_one(work, mode_right, mode_arith);

    // All outputs are pure decodes of registered state.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = (shamt != '0) ? SHIFT : DONE;
            SHIFT:   if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control and visible result: cleared by reset so an aborted request
    // leaves nothing presentable behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            data_out <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= shamt;
                // Zero-length shift completes immediately with the operand.
                if (shamt == '0) data_out <= i_data;
            end else if (state == SHIFT) begin
                cnt <= cnt - 1'b1;
                // data_out only changes on completion, so it keeps the
                // previous result while the next one is being computed.
                if (last_step) data_out <= work_shifted;
            end
        end
    end

    // Working datapath: only meaningful while SHIFT, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            work       <= i_data;
            mode_right <= L_R;
            mode_arith <= A_L;
        end else if (state == SHIFT) begin
            work <= work_shifted;
        end
    end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Multi-cycle, bit-serial counterpart of the team's combinational 8-bit barrel shifter, for area-constrained paths on the nvboard designs.
- Accepts an operand and shift amount over a valid/ready handshake, shifts one bit position per clock, then presents the result over a second valid/ready handshake.
- Supports left/right and logical/arithmetic shifts, with the same fill rules as the combinational shifter, so the two are interchangeable result-for-result.

Parameters:
- DATA_WIDTH, 8, operand/result width in bits (>=2).
- SHAMT_WIDTH, 3, shift-amount width; maximum shift is 2^SHAMT_WIDTH-1, and it must be < DATA_WIDTH.

Ports:
- clk  input  1  sole clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request carries a valid operand.
- in_ready  output  1  block can accept a request.
- i_data  input  DATA_WIDTH  operand.
- shamt  input  SHAMT_WIDTH  shift amount.
- L_R  input  1  1 = shift right, 0 = shift left.
- A_L  input  1  1 = arithmetic fill, 0 = logical (zero) fill.
- out_valid  output  1  data_out holds a completed result.
- out_ready  input  1  consumer accepts the result.
- data_out  output  DATA_WIDTH  shifted result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (async, asserts immediately): state = IDLE; in_ready = 1; out_valid = 0; busy = 0; data_out = 0; internal counter = 0.
- Reset mid-operation aborts the operation. No result is ever presented for an aborted request.
- States: IDLE, SHIFT, DONE. in_ready = (state==IDLE); out_valid = (state==DONE); busy = !IDLE.
- IDLE:
  - On an edge with in_valid&&in_ready, latch i_data into the working register, shamt into the counter, and L_R/A_L into mode flags.
  - Next state is SHIFT if shamt != 0, else DONE.
  - Inputs are ignored at all other times and in all other states.
- SHIFT: each edge performs one 1-bit shift of the working register and decrements the counter.
  - When the counter goes 1->0, next state = DONE.
  - Right logical: MSB fill 0.
  - Right arithmetic: MSB fill with current MSB (sign replicate).
  - Left logical: LSB fill 0.
  - Left arithmetic: LSB fill with current bit 0 (LSB replicate; matches the combinational shifter, not a plain <<).
- Latency:
  - Request accepted at edge N with shamt=k: out_valid is high after edge N+k for k>=1, and after edge N for k=0.
  - k=0 returns i_data unchanged.
- DONE:
  - data_out is stable and equals the working register; it does not change while out_valid=1 and out_ready=0 (backpressure holds indefinitely).
  - On an edge with out_ready=1, the result transfers and next state = IDLE. data_out keeps the last result until the next DONE.
- No overlap: a new request cannot be accepted in the same cycle a result is consumed. in_ready rises the cycle after the transfer, giving a minimum issue interval of k+2 cycles.
- The mode flags and counter are used only from their latched copies. Input changes after acceptance have no effect.
- The counter is SHAMT_WIDTH bits with no wrap: max shamt = 2^SHAMT_WIDTH-1 completes normally (7 cycles at defaults).
- Combinational outputs contain no loops. All outputs derive from registered state.

Test Plan:
- Reset check: assert rst asynchronously mid-SHIFT (i_data=8'hB4, shamt=7) -> in_ready=1, out_valid=0, busy=0, data_out=0 immediately. After release, no spurious out_valid.
- Right shifts: i_data=8'hB4, shamt=3, L_R=1 -> A_L=1 gives 8'hF6 and A_L=0 gives 8'h16. out_valid appears exactly 3 edges after acceptance.
- Left shifts: i_data=8'h2D, shamt=2, L_R=0 -> A_L=1 gives 8'hB7 (LSB replicate) and A_L=0 gives 8'hB4. Also i_data=8'hB4, shamt=3, A_L=0 -> 8'hA0.
- Boundaries: shamt=0, i_data=8'h5A -> 8'h5A with out_valid after 1 edge. shamt=7, right arithmetic, i_data=8'h80 -> 8'hFF; right logical -> 8'h01; left logical, i_data=8'h01 -> 8'h80.
- Backpressure/ignore: hold out_ready=0 for 10 cycles with in_valid=1 and changing i_data/L_R -> data_out stable, in_ready=0, no new request accepted. Raise out_ready -> one transfer, in_ready=1 next cycle.
- Random back-to-back: 500 random requests with random out_ready -> every result matches the combinational reference shifter model, with no lost or duplicated results.
